// File: rtl/frame_loader.sv
`default_nettype none
// ============================================================================
//  Module   : frame_loader
//  Purpose  : Streams one frame of RGB pixels from a valid/ready source into
//             an adapter's ping-pong line buffers. Each line is written to the
//             buffer selected by BufSel, which alternates every line. Before
//             each line the loader waits for the selected buffer to be free.
//  Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                 : clock, all logic on rising edge
//    reset               : synchronous active-high reset
//    AIPOut_PD[9:0]      : active pixels per line (latched on accepted start)
//    AILOut_PD[9:0]      : active lines per frame (latched on accepted start)
//    start               : one-cycle frame load request (honoured in IDLE only)
//    PxValid, PxR/G/B    : pixel source stream
//    PxReady             : pixel accepted when PxValid & PxReady
//    Buf0Empty/Buf1Empty : line buffer 0/1 free
//    WData[31:0]         : packed pixel word {8'h00, R, G, B}
//    WE0/WE1             : one-cycle write strobe to buffer 0/1
//    CSDisplay           : frame in progress
//    FrameDone, CfgErr   : one-cycle status pulses
//    FrameCount[15:0]    : completed frames, wrapping
//                          (present only with FRAME_LOADER_FRAME_CNT_EN)
//  Build option
//    FRAME_LOADER_FRAME_CNT_EN : adds the FrameCount output and its register
// ============================================================================
module frame_loader (
    input  logic        clk,
    input  logic        reset,
    input  logic [9:0]  AIPOut_PD,
    input  logic [9:0]  AILOut_PD,
    input  logic        start,
    input  logic        PxValid,
    input  logic [7:0]  PxR,
    input  logic [7:0]  PxG,
    input  logic [7:0]  PxB,
    output logic        PxReady,
    input  logic        Buf0Empty,
    input  logic        Buf1Empty,
    output logic [31:0] WData,
    output logic        WE0,
    output logic        WE1,
    output logic        CSDisplay,
    output logic        FrameDone,
    output logic        CfgErr
`ifdef FRAME_LOADER_FRAME_CNT_EN
    ,
    output logic [15:0] FrameCount
`endif
);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_WAIT_BUF = 2'd1,
        S_LOAD     = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t      r_state;
    state_t      w_state_next;

    logic [9:0]  r_aip;
    logic [9:0]  r_ail;
    logic [9:0]  r_pix_cnt;
    logic [9:0]  r_line_cnt;
    logic        r_buf_sel;
    logic [31:0] r_wdata;
    logic        r_we0;
    logic        r_we1;
    logic        r_cfg_err;

    logic        w_cfg_ok;
    logic        w_start_ok;
    logic        w_accept;
    logic        w_line_end;
    logic        w_last_line;
    logic        w_buf_empty;

    assign w_cfg_ok    = (AIPOut_PD != 10'd0) && (AILOut_PD != 10'd0);
    assign w_start_ok  = (r_state == S_IDLE) && start && w_cfg_ok;
    assign w_accept    = (r_state == S_LOAD) && PxValid;
    assign w_line_end  = w_accept && (r_pix_cnt == (r_aip - 10'd1));
    assign w_last_line = (r_line_cnt == (r_ail - 10'd1));
    assign w_buf_empty = r_buf_sel ? Buf1Empty : Buf0Empty;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start_ok) begin
                    w_state_next = S_WAIT_BUF;
                end
            end
            S_WAIT_BUF: begin
                if (w_buf_empty) begin
                    w_state_next = S_LOAD;
                end
            end
            S_LOAD: begin
                if (w_line_end) begin
                    w_state_next = w_last_line ? S_DONE : S_WAIT_BUF;
                end
            end
            S_DONE: begin
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath: latched geometry, counters, buffer select, write port.
    // The write strobe is registered, so the last pixel of a line is still
    // written in the cycle after the FSM has left LOAD.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_aip      <= 10'd0;
            r_ail      <= 10'd0;
            r_pix_cnt  <= 10'd0;
            r_line_cnt <= 10'd0;
            r_buf_sel  <= 1'b0;
            r_wdata    <= 32'd0;
            r_we0      <= 1'b0;
            r_we1      <= 1'b0;
            r_cfg_err  <= 1'b0;
        end else begin
            r_we0     <= 1'b0;
            r_we1     <= 1'b0;
            r_cfg_err <= 1'b0;

            if ((r_state == S_IDLE) && start) begin
                if (w_cfg_ok) begin
                    r_aip      <= AIPOut_PD;
                    r_ail      <= AILOut_PD;
                    r_pix_cnt  <= 10'd0;
                    r_line_cnt <= 10'd0;
                    r_buf_sel  <= 1'b0;
                end else begin
                    r_cfg_err  <= 1'b1;
                end
            end

            if (w_accept) begin
                r_wdata <= {8'h00, PxR, PxG, PxB};
                r_we0   <= ~r_buf_sel;
                r_we1   <= r_buf_sel;
                if (w_line_end) begin
                    r_pix_cnt  <= 10'd0;
                    r_line_cnt <= r_line_cnt + 10'd1;
                    r_buf_sel  <= ~r_buf_sel;
                end else begin
                    r_pix_cnt  <= r_pix_cnt + 10'd1;
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs. Gating with reset forces every output to 0 for the whole
    // time reset is high, including the first cycle before the registers
    // have been cleared by a clock edge.
    // ------------------------------------------------------------------
    assign PxReady   = ~reset & (r_state == S_LOAD);
    assign CSDisplay = ~reset & ((r_state == S_WAIT_BUF) || (r_state == S_LOAD));
    assign FrameDone = ~reset & (r_state == S_DONE);
    assign CfgErr    = ~reset & r_cfg_err;
    assign WE0       = ~reset & r_we0;
    assign WE1       = ~reset & r_we1;
    assign WData     = reset ? 32'd0 : r_wdata;

`ifdef FRAME_LOADER_FRAME_CNT_EN
    logic [15:0] r_frame_cnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame_cnt <= 16'd0;
        end else if (r_state == S_DONE) begin
            r_frame_cnt <= r_frame_cnt + 16'd1;
        end
    end

    assign FrameCount = r_frame_cnt;
`endif

endmodule

`default_nettype wire

// File: doc/frame_loader.md
FRAME_LOADER -- requirements
Module: frame_loader

Interface
REQ-001 The module SHALL have the port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-002 The module SHALL have the port reset, input, 1 bit: synchronous, active-high reset.
REQ-003 The module SHALL have the port AIPOut_PD, input, 10 bits: active pixels per line, sampled on an accepted start.
REQ-004 The module SHALL have the port AILOut_PD, input, 10 bits: active lines per frame, sampled on an accepted start.
REQ-005 The module SHALL have the port start, input, 1 bit: a one-cycle request to load one frame.
REQ-006 The module SHALL have the ports PxValid, input, 1 bit; PxR, PxG and PxB, input, 8 bits each: the pixel source stream.
REQ-007 The module SHALL have the port PxReady, output, 1 bit: the pixel is accepted when PxValid and PxReady are both 1.
REQ-008 The module SHALL have the ports Buf0Empty and Buf1Empty, input, 1 bit each: the adapter's ping-pong line buffer is free.
REQ-009 The module SHALL have the port WData, output, 32 bits: the packed pixel word {8'h00, R, G, B}.
REQ-010 The module SHALL have the ports WE0 and WE1, output, 1 bit each: one-cycle write strobes for buffer 0 and buffer 1.
REQ-011 The module SHALL have the port CSDisplay, output, 1 bit: held at 1 from an accepted start until DONE is entered.
REQ-012 The module SHALL have the ports FrameDone and CfgErr, output, 1 bit each: one-cycle status pulses.

Function
REQ-013 The FSM SHALL have the states IDLE, WAIT_BUF, LOAD and DONE.
REQ-014 IDLE: start with AIPOut_PD≠0 and AILOut_PD≠0 SHALL latch both counts, clear the pixel and line counters, set BufSel=0 and go to WAIT_BUF.
REQ-015 IDLE: start with either count equal to 0 SHALL pulse CfgErr for one cycle and stay in IDLE.
REQ-016 start SHALL be ignored in every state except IDLE.
REQ-017 WAIT_BUF SHALL go to LOAD in the cycle after the empty flag of the buffer selected by BufSel is seen at 1.
REQ-018 PxReady SHALL equal 1 exactly when the state is LOAD; it is 0 combinationally in every other state.
REQ-019 Each accepted pixel SHALL be registered into WData in the next cycle, together with a one-cycle WE0 (BufSel=0) or WE1 (BufSel=1); latency is exactly 1 cycle.
REQ-020 WData SHALL hold its last value while WE0 and WE1 are both 0.
REQ-021 The pixel counter SHALL increment on each accept.
REQ-022 An accept with pixel count = latched AIP-1 SHALL end the line: clear the pixel counter, increment the line counter and toggle BufSel.
REQ-023 After a line ends, the FSM SHALL go to WAIT_BUF, or to DONE if the line that ended was line latched AIL-1.
REQ-024 The write strobe for the last pixel of a line SHALL still be issued in the cycle after the accept, even though the state has already left LOAD.
REQ-025 DONE SHALL last one cycle, pulse FrameDone and drop CSDisplay, then go to IDLE.
REQ-026 A frame with AIP=1 and AIL=1 SHALL need one accept, and FrameDone SHALL occur 2 cycles after WAIT_BUF sees the buffer empty.
REQ-027 PxValid held at 0 in LOAD SHALL stall the FSM indefinitely with no timeout.
REQ-028 Changes to AIPOut_PD or AILOut_PD during a frame SHALL have no effect until the next accepted start.
REQ-029 Both WE0 and WE1 SHALL never be 1 in the same cycle.

Reset
REQ-030 While reset=1 the FSM SHALL go to IDLE, and the counters, BufSel and the latched counts SHALL be cleared.
REQ-031 While reset=1, WData SHALL be 0 and PxReady, WE0, WE1, CSDisplay, FrameDone and CfgErr SHALL all be 0.
REQ-032 A reset in the middle of a frame SHALL abandon the frame with no FrameDone and no further strobes, including any strobe still pending from an accept.
REQ-033 reset SHALL take priority over start.

Configuration
REQ-034 When the macro FRAME_LOADER_FRAME_CNT_EN is defined, the module SHALL add FrameCount, output, 16 bits: reset to 0, incremented when FrameDone pulses, wrapping from 16'hFFFF to 0.
REQ-035 When FRAME_LOADER_FRAME_CNT_EN is undefined, FrameCount and its register SHALL be absent and all other behaviour SHALL be identical.

Verification
REQ-036 Bench: AIP=4, AIL=2, both buffers empty, PxValid held at 1, pixels 0x112233 to 0x887766 -> 4 WE0 pulses then 4 WE1 pulses with WData=0x00RRGGBB in order, then one FrameDone pulse.
REQ-037 Bench: Buf1Empty held at 0 for 10 cycles after line 0 ends -> PxReady=0 and no WE1 pulse for those 10 cycles; loading resumes 1 cycle after Buf1Empty=1.
REQ-038 Bench: start with AIPOut_PD=0 -> one CfgErr pulse, CSDisplay stays 0, state stays IDLE.
REQ-039 Bench: reset asserted during the same cycle as the 3rd pixel accept -> no WE pulse in the next cycle, all outputs 0, and a following start reloads from line 0.
REQ-040 Bench: AIP=1, AIL=1 with a second start issued while busy -> exactly one WE0 pulse and one FrameDone pulse; the second start is ignored.
REQ-041 Bench (FRAME_LOADER_FRAME_CNT_EN defined): FrameCount preset via 65536 frames of AIP=1, AIL=1 -> FrameCount wraps to 0.
